// File: rtl/fpu_defs_fmul_seq.sv
// ============================================================================
// Module  : fpu_defs_fmul_seq (package)
// Brief   : Rounding modes, FSM state encoding and flag indices for fpu_fmul_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpu_defs_fmul_seq;

    localparam logic [1:0] C_RM_NEAREST  = 2'd0;
    localparam logic [1:0] C_RM_TRUNC    = 2'd1;
    localparam logic [1:0] C_RM_PLUSINF  = 2'd2;
    localparam logic [1:0] C_RM_MINUSINF = 2'd3;

    localparam logic [1:0] C_STATE_IDLE  = 2'd0;
    localparam logic [1:0] C_STATE_MUL   = 2'd1;
    localparam logic [1:0] C_STATE_ROUND = 2'd2;
    localparam logic [1:0] C_STATE_DONE  = 2'd3;

    // Flag vector layout is {NV, OF, UF, NX}
    localparam int C_FLAG_NV = 3;
    localparam int C_FLAG_OF = 2;
    localparam int C_FLAG_UF = 1;
    localparam int C_FLAG_NX = 0;

endpackage

`default_nettype wire

// File: rtl/fpu_fmul_seq_round.sv
// ============================================================================
// Module  : fpu_fmul_seq_round
// Brief   : Combinational normalise / round / overflow / underflow stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_fmul_seq_round
    import fpu_defs_fmul_seq::*;
#(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23
) (
    input  logic [2*C_MANT+1:0]      Product_DI,
    input  logic signed [C_EXP+1:0]  Exp_DI,
    input  logic                     Sign_SI,
    input  logic [1:0]               RM_SI,
    output logic [C_EXP+C_MANT:0]    Result_DO,
    output logic [3:0]               Flags_SO
);

    localparam logic signed [C_EXP+1:0] c_exp_max  = {2'b00, {C_EXP{1'b1}}};
    localparam logic signed [C_EXP+1:0] c_exp_zero = '0;

    logic                     w_msb;
    logic [2*C_MANT+1:0]      w_norm;
    logic [C_MANT-1:0]        w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_inexact;
    logic                     w_inc;
    logic [C_MANT:0]          w_mant_rnd;
    logic signed [C_EXP+1:0]  w_exp_norm;
    logic signed [C_EXP+1:0]  w_exp_rnd;
    logic                     w_to_inf;

    // Align so the leading one always sits at bit 2*C_MANT
    assign w_msb      = Product_DI[2*C_MANT+1];
    assign w_norm     = w_msb ? Product_DI : (Product_DI << 1);
    assign w_mant     = w_norm[2*C_MANT:C_MANT+1];
    assign w_guard    = w_norm[C_MANT];
    assign w_sticky   = |w_norm[C_MANT-1:0];
    assign w_inexact  = w_guard | w_sticky;
    assign w_exp_norm = Exp_DI + $signed({{(C_EXP+1){1'b0}}, w_msb});

    always_comb begin
        w_inc = 1'b0;
        case (RM_SI)
            C_RM_NEAREST:  w_inc = w_guard & (w_sticky | w_mant[0]);
            C_RM_TRUNC:    w_inc = 1'b0;
            C_RM_PLUSINF:  w_inc = w_inexact & ~Sign_SI;
            C_RM_MINUSINF: w_inc = w_inexact & Sign_SI;
            default:       w_inc = 1'b0;
        endcase
    end

    assign w_mant_rnd = {1'b0, w_mant} + {{C_MANT{1'b0}}, w_inc};
    assign w_exp_rnd  = w_exp_norm + $signed({{(C_EXP+1){1'b0}}, w_mant_rnd[C_MANT]});
    assign w_to_inf   = (RM_SI == C_RM_NEAREST) ||
                        ((RM_SI == C_RM_PLUSINF) && !Sign_SI) ||
                        ((RM_SI == C_RM_MINUSINF) && Sign_SI);

    always_comb begin
        Result_DO            = {Sign_SI, w_exp_rnd[C_EXP-1:0], w_mant_rnd[C_MANT-1:0]};
        Flags_SO             = '0;
        Flags_SO[C_FLAG_NX]  = w_inexact;
        if (w_exp_norm <= c_exp_zero) begin
            Result_DO           = {Sign_SI, {(C_EXP+C_MANT){1'b0}}};
            Flags_SO[C_FLAG_UF] = 1'b1;
            Flags_SO[C_FLAG_NX] = 1'b1;
        end else if (w_exp_rnd >= c_exp_max) begin
            Flags_SO[C_FLAG_OF] = 1'b1;
            Flags_SO[C_FLAG_NX] = 1'b1;
            if (w_to_inf)
                Result_DO = {Sign_SI, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            else
                Result_DO = {Sign_SI, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_fmul_seq.sv
// ============================================================================
// Module  : fpu_fmul_seq
// Brief   : Iterative radix-2 shift-add FP multiplier, valid/ready handshake.
//           Optional sticky flag accumulator: FPU_FMUL_STICKY_FLAGS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_fmul_seq
    import fpu_defs_fmul_seq::*;
#(
    parameter  int C_EXP  = 8,
    parameter  int C_MANT = 23,
    localparam int C_OP   = 1 + C_EXP + C_MANT,
    localparam int C_BIAS = 2**(C_EXP-1) - 1
) (
    input  logic            Clk_CI,
    input  logic            Rst_RI,
    input  logic [C_OP-1:0] Operand_a_DI,
    input  logic [C_OP-1:0] Operand_b_DI,
    input  logic [1:0]      RM_SI,
    input  logic            Valid_SI,
    output logic            Ready_SO,
    output logic [C_OP-1:0] Result_DO,
    output logic            NV_SO,
    output logic            OF_SO,
    output logic            UF_SO,
    output logic            NX_SO,
    output logic            Valid_SO,
    input  logic            Ready_SI
`ifdef FPU_FMUL_STICKY_FLAGS_EN
    ,
    input  logic            Clear_flags_SI,
    output logic [3:0]      Flags_SO
`endif
);

    localparam int                c_cnt_w    = $clog2(C_MANT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(C_MANT);
    localparam logic [C_EXP+1:0]   c_bias     = (C_EXP+2)'(C_BIAS);
    localparam logic [C_OP-1:0]    c_qnan     = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

    logic [1:0]              r_state;
    logic [C_MANT:0]         r_mcand;
    logic [C_MANT:0]         r_mplier;
    logic [2*C_MANT+1:0]     r_acc;
    logic [c_cnt_w-1:0]      r_cnt;
    logic signed [C_EXP+1:0] r_exp;
    logic                    r_sign;
    logic [1:0]              r_rm;
    logic [C_OP-1:0]         r_result;
    logic [3:0]              r_flags;

    logic [C_EXP-1:0]  w_a_exp, w_b_exp;
    logic [C_MANT-1:0] w_a_man, w_b_man;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic              w_sign;
    logic              w_special;
    logic [C_OP-1:0]   w_spec_result;
    logic [3:0]        w_spec_flags;
    logic [C_MANT+1:0] w_partial;
    logic [C_OP-1:0]   w_rnd_result;
    logic [3:0]        w_rnd_flags;

    assign w_a_exp  = Operand_a_DI[C_OP-2:C_MANT];
    assign w_b_exp  = Operand_b_DI[C_OP-2:C_MANT];
    assign w_a_man  = Operand_a_DI[C_MANT-1:0];
    assign w_b_man  = Operand_b_DI[C_MANT-1:0];
    assign w_sign   = Operand_a_DI[C_OP-1] ^ Operand_b_DI[C_OP-1];
    // Exponent zero covers subnormals too: they flush to signed zero
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (&w_a_exp) && (w_a_man == '0);
    assign w_b_inf  = (&w_b_exp) && (w_b_man == '0);
    assign w_a_nan  = (&w_a_exp) && (w_a_man != '0);
    assign w_b_nan  = (&w_b_exp) && (w_b_man != '0);
    assign w_a_snan = w_a_nan && !w_a_man[C_MANT-1];
    assign w_b_snan = w_b_nan && !w_b_man[C_MANT-1];
    assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;

    always_comb begin
        w_spec_result = {w_sign, {(C_EXP+C_MANT){1'b0}}};
        w_spec_flags  = '0;
        if (w_a_nan || w_b_nan) begin
            w_spec_result           = c_qnan;
            w_spec_flags[C_FLAG_NV] = w_a_snan | w_b_snan;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_spec_result           = c_qnan;
            w_spec_flags[C_FLAG_NV] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_spec_result = {w_sign, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
        end
    end

    // Add into the upper half, then shift the whole accumulator right one place
    assign w_partial = {1'b0, r_acc[2*C_MANT+1:C_MANT+1]} +
                       (r_mplier[0] ? {1'b0, r_mcand} : '0);

    fpu_fmul_seq_round #(
        .C_EXP  (C_EXP),
        .C_MANT (C_MANT)
    ) u_round (
        .Product_DI (r_acc),
        .Exp_DI     (r_exp),
        .Sign_SI    (r_sign),
        .RM_SI      (r_rm),
        .Result_DO  (w_rnd_result),
        .Flags_SO   (w_rnd_flags)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            r_state  <= C_STATE_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_sign   <= 1'b0;
            r_rm     <= C_RM_NEAREST;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                C_STATE_IDLE: begin
                    if (Valid_SI) begin
                        r_mcand  <= {1'b1, w_a_man};
                        r_mplier <= {1'b1, w_b_man};
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_exp    <= {2'b00, w_a_exp} + {2'b00, w_b_exp} - c_bias;
                        r_sign   <= w_sign;
                        r_rm     <= RM_SI;
                        if (w_special) begin
                            r_result <= w_spec_result;
                            r_flags  <= w_spec_flags;
                            r_state  <= C_STATE_DONE;
                        end else begin
                            r_state  <= C_STATE_MUL;
                        end
                    end
                end
                C_STATE_MUL: begin
                    r_acc    <= {w_partial, r_acc[C_MANT:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last)
                        r_state <= C_STATE_ROUND;
                end
                C_STATE_ROUND: begin
                    r_result <= w_rnd_result;
                    r_flags  <= w_rnd_flags;
                    r_state  <= C_STATE_DONE;
                end
                C_STATE_DONE: begin
                    if (Ready_SI)
                        r_state <= C_STATE_IDLE;
                end
                default: r_state <= C_STATE_IDLE;
            endcase
        end
    end

    assign Ready_SO  = (r_state == C_STATE_IDLE);
    assign Valid_SO  = (r_state == C_STATE_DONE);
    assign Result_DO = r_result;
    assign NV_SO     = r_flags[C_FLAG_NV];
    assign OF_SO     = r_flags[C_FLAG_OF];
    assign UF_SO     = r_flags[C_FLAG_UF];
    assign NX_SO     = r_flags[C_FLAG_NX];

`ifdef FPU_FMUL_STICKY_FLAGS_EN
    logic [3:0] r_sticky;

    // Clear acts before the OR so a coincident handshake's flags survive
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI)
            r_sticky <= '0;
        else
            r_sticky <= (Clear_flags_SI ? 4'b0000 : r_sticky) |
                        ((Valid_SO && Ready_SI) ? r_flags : 4'b0000);
    end

    assign Flags_SO = r_sticky;
`endif

endmodule

`default_nettype wire

// File: doc/fpu_fmul_seq.md
Name: fpu_fmul_seq

Overview:
- Parametrised-format, iterative (radix-2 shift-add) floating-point multiplier.
- Generalises the fixed single-precision FMAC constant set to any C_EXP/C_MANT pair.
- Sits beside the FMAC as a low-area multiply unit behind a valid/ready handshake.
- Supports all four rounding modes; subnormals are flushed to zero.

Parameters:
- C_EXP, 8, exponent width.
- C_MANT, 23, stored mantissa width.
- C_OP, 1+C_EXP+C_MANT, operand/result width (derived, not overridable).
- C_BIAS, 2**(C_EXP-1)-1, exponent bias (derived).

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  reset, synchronous, active-high.
- Operand_a_DI  in  C_OP  multiplicand.
- Operand_b_DI  in  C_OP  multiplier.
- RM_SI  in  2  rounding mode: 0 nearest-even, 1 toward zero, 2 +inf, 3 -inf.
- Valid_SI  in  1  input valid.
- Ready_SO  out  1  input ready.
- Result_DO  out  C_OP  product.
- NV_SO, OF_SO, UF_SO, NX_SO  out  1 each  invalid / overflow / underflow / inexact flags, qualified by Valid_SO.
- Valid_SO  out  1  result valid.
- Ready_SI  in  1  downstream ready.

Behaviour:
- Clock and reset: single clock Clk_CI; Rst_RI is synchronous, active-high.
- Reset values: state IDLE, Ready_SO=1, Valid_SO=0, Result_DO=0, all flags 0.
- States: IDLE, MUL, ROUND, DONE.
  - IDLE: Ready_SO=1. An accept (Valid_SI & Ready_SO) registers operands and RM.
    - Special operand: go to DONE with the special result precomputed.
    - Otherwise: go to MUL.
  - MUL: C_MANT+1 iterations. Each iteration inspects one multiplier bit, LSB first, and adds the multiplicand into a 2*C_MANT+2 bit accumulator.
  - ROUND: one cycle, then DONE.
  - DONE: Valid_SO=1; outputs stable until Ready_SI. On Valid_SO & Ready_SI go to IDLE.
- Ready_SO is high only in IDLE, so there is no accept in the cycle a result leaves.
- Latency:
  - Normal path: Valid_SO rises C_MANT+3 cycles after the accept cycle (26 for single precision).
  - Special path: Valid_SO rises 1 cycle after the accept cycle.
- Input classification:
  - Exponent 0 means zero; nonzero mantissa is flushed to signed zero, no flag.
  - Exponent all-ones with mantissa 0 is Inf; with nonzero mantissa it is NaN.
  - A NaN is signalling when mantissa MSB=0.
- Special results, in priority order:
  - Any NaN operand: canonical qNaN (sign 0, exponent all-ones, mantissa 1<<(C_MANT-1)). NV=1 if any operand is an sNaN.
  - Inf*zero: qNaN, NV=1.
  - Inf*x: Inf, sign = XOR of operand signs.
  - Zero*x: signed zero.
- Arithmetic:
  - Significands carry the implicit 1 (C_MANT+1 bits).
  - Exponent is signed, C_EXP+2 bits: ea+eb-C_BIAS.
  - If product MSB is set, shift right 1 and exponent +1.
  - Keep C_MANT bits, guard bit, sticky = OR of the rest.
- Rounding:
  - RNE: increment if guard & (sticky | LSB).
  - RTZ: never increment.
  - +inf: increment on (guard|sticky) & positive.
  - -inf: increment on (guard|sticky) & negative.
  - Mantissa carry-out increments the exponent.
- Overflow (post-round exponent >= 2**C_EXP-1): OF=1, NX=1. Result is Inf for RNE, for +inf when positive, and for -inf when negative; otherwise max finite (exponent all-ones-1, mantissa all-ones).
- Underflow (pre-round exponent <= 0): signed zero, UF=1, NX=1.
- NX = guard|sticky on the normal path.
- Reset while in MUL or ROUND: the operation is discarded and no Valid_SO pulse occurs.
- RM_SI and operand changes after accept have no effect on the operation in flight.

Optional Feature:
- Macro FPU_FMUL_STICKY_FLAGS_EN.
- When defined:
  - Adds port Clear_flags_SI (in, 1) and port Flags_SO (out, 4, {NV,OF,UF,NX}).
  - Flags_SO accumulates the OR of each result's flags on the DONE handshake cycle.
  - Clear_flags_SI zeroes Flags_SO next cycle. A simultaneous handshake is cleared first, then its flags are ORed in, so the new flags survive.
  - Reset value of Flags_SO is 0.
- When undefined: neither port exists; per-result flags only.

Decomposition:
- Package fpu_defs_fmul_seq holds:
  - rounding-mode constants (C_RM_NEAREST, C_RM_TRUNC, C_RM_PLUSINF, C_RM_MINUSINF);
  - the state enum;
  - the flag-vector index constants.
- Sub-module fpu_fmul_seq_round: combinational normalise/round/overflow/underflow. Takes product, exponent, sign and RM; returns result and flags. Instantiated in ROUND.

Test Plan:
- 0x3FC00000 * 0x40000000, RNE -> 0x40400000, no flags; Valid_SO exactly 26 cycles after accept.
- 0x3F800001 * 0x3F800001: RNE -> 0x3F800002, NX=1; +inf -> 0x3F800003, NX=1; RTZ -> 0x3F800002.
- 0x7F7FFFFF * 0x40000000: RNE -> 0x7F800000, OF=NX=1; RTZ -> 0x7F7FFFFF, OF=NX=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000, NV=1, Valid_SO 1 cycle after accept. 0x7F800001 * 0x3F800000 -> 0x7FC00000, NV=1.
- Backpressure and mid-op reset:
  - Hold Ready_SI=0 for 5 cycles in DONE: Result_DO and flags stable, Ready_SO=0.
  - Assert Rst_RI in the 10th MUL cycle: next cycle IDLE, Valid_SO=0, no result emitted.
- With FPU_FMUL_STICKY_FLAGS_EN:
  - Overflow op then an exact op: Flags_SO=0b0101.
  - Clear_flags_SI during an NX result handshake: Flags_SO=0b0001.
